// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types for the DMA slave-port arbiter.
// Transfer, burst and response encodings plus the arbiter state type.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } HBURST_Type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_state;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    function automatic logic is_active(HTRANS_state t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb3lite_dma_arbiter_if.sv
// Bus bundle between the DMA channel masters, the arbiter and the slave.
// slave: arbiter view; master: view of the masters and the slave model.
interface ahb3lite_dma_arbiter_if #(
    parameter int N = 2
);
    import ahb3lite_pkg::*;

    logic [N-1:0] m_HBUSREQ;
    logic [31:0]  m_HADDR  [N];
    HTRANS_state  m_HTRANS [N];
    HBURST_Type   m_HBURST [N];
    logic [2:0]   m_HSIZE  [N];
    logic [N-1:0] m_HWRITE;
    logic [N-1:0] m_HGRANT;
    logic         m_HREADY;
    HRESP_state   m_HRESP  [N];
    logic [31:0]  m_HRDATA;

    logic [31:0]  s_HADDR;
    HTRANS_state  s_HTRANS;
    HBURST_Type   s_HBURST;
    logic [2:0]   s_HSIZE;
    logic         s_HWRITE;
    logic         s_HREADYOUT;
    HRESP_state   s_HRESP;
    logic [31:0]  s_HRDATA;

    modport slave (
        input  m_HBUSREQ, m_HADDR, m_HTRANS, m_HBURST, m_HSIZE, m_HWRITE,
        output m_HGRANT, m_HREADY, m_HRESP, m_HRDATA,
        output s_HADDR, s_HTRANS, s_HBURST, s_HSIZE, s_HWRITE,
        input  s_HREADYOUT, s_HRESP, s_HRDATA
    );

    modport master (
        output m_HBUSREQ, m_HADDR, m_HTRANS, m_HBURST, m_HSIZE, m_HWRITE,
        input  m_HGRANT, m_HREADY, m_HRESP, m_HRDATA,
        input  s_HADDR, s_HTRANS, s_HBURST, s_HSIZE, s_HWRITE,
        output s_HREADYOUT, s_HRESP, s_HRDATA
    );

endinterface

// File: rtl/ahb3lite_rr_picker.sv
// Round-robin winner search starting at ptr, skipping masked requesters.
// Purely combinational.
module ahb3lite_rr_picker #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int            c;
    logic [IW-1:0] ci;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        ci    = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            ci = IW'(c);
            if (!valid && req[ci] && !excl[ci]) begin
                valid = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/ahb3lite_dma_arbiter.sv
// Arbiter sharing one AHB-Lite DMA slave port among N_MASTERS requesters.
// Grants change only at release points; round-robin with bounded tenure.
module ahb3lite_dma_arbiter
    import ahb3lite_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 16,
    localparam int IW = $clog2(N_MASTERS),
    localparam int HW = $clog2(MAX_HOLD + 1)
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    ahb3lite_dma_arbiter_if.slave   bus,
    output logic [IW-1:0]           owner_idx
);

    arb_state_t             state;
    logic [N_MASTERS-1:0]   grant;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          d_owner;
    logic                   d_valid;
    logic [HW-1:0]          hold;
    logic [IW-1:0]          rr_ptr;

    logic [IW-1:0]          win;
    logic                   win_valid;
    logic [IW-1:0]          nxt_ptr;
    logic [N_MASTERS-1:0]   win_oh;

    logic [31:0]            s_addr;
    HTRANS_state            s_trans;
    HBURST_Type             s_burst;
    logic [2:0]             s_size;
    logic                   s_write;

    logic                   s_act;
    logic                   rel;
    logic                   owner_req;
    logic                   at_max;

    // The current owner is masked out, so win is always "someone else".
    ahb3lite_rr_picker #(.N(N_MASTERS)) u_pick (
        .req   (bus.m_HBUSREQ),
        .ptr   (rr_ptr),
        .excl  (grant),
        .idx   (win),
        .valid (win_valid)
    );

    always_comb begin
        s_addr  = '0;
        s_trans = IDLE;
        s_burst = SINGLE;
        s_size  = '0;
        s_write = 1'b0;
        if (HRESETn && |grant) begin
            s_addr  = bus.m_HADDR[owner];
            s_trans = bus.m_HTRANS[owner];
            s_burst = bus.m_HBURST[owner];
            s_size  = bus.m_HSIZE[owner];
            s_write = bus.m_HWRITE[owner];
        end
    end

    assign bus.s_HADDR  = s_addr;
    assign bus.s_HTRANS = s_trans;
    assign bus.s_HBURST = s_burst;
    assign bus.s_HSIZE  = s_size;
    assign bus.s_HWRITE = s_write;

    assign bus.m_HGRANT = grant;
    assign bus.m_HREADY = bus.s_HREADYOUT;
    assign bus.m_HRDATA = bus.s_HRDATA;
    assign owner_idx    = owner;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            bus.m_HRESP[i] = (d_valid && d_owner == IW'(i)) ? bus.s_HRESP : OKAY;
        end
    end

    assign s_act     = is_active(s_trans);
    assign rel       = bus.s_HREADYOUT && (bus.m_HTRANS[owner] == IDLE);
    assign owner_req = bus.m_HBUSREQ[owner];
    assign at_max    = (hold == HW'(MAX_HOLD));
    assign nxt_ptr   = (win == IW'(N_MASTERS - 1)) ? '0 : win + 1'b1;

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            owner   <= '0;
            d_owner <= '0;
            d_valid <= 1'b0;
            hold    <= '0;
            rr_ptr  <= '0;
        end else begin
            if (bus.s_HREADYOUT) begin
                d_valid <= s_act;
                if (s_act) d_owner <= owner;
            end
            unique case (state)
                ARB_IDLE: begin
                    if (win_valid) begin
                        grant  <= win_oh;
                        owner  <= win;
                        rr_ptr <= nxt_ptr;
                        hold   <= '0;
                        state  <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    if (bus.s_HREADYOUT && s_act && !at_max) hold <= hold + 1'b1;
                    // rel implies the owner is IDLE, so hold never counts here
                    if (rel) begin
                        if (!owner_req && !win_valid) begin
                            grant <= '0;
                            state <= ARB_IDLE;
                        end else if (win_valid && (!owner_req || at_max)) begin
                            grant  <= win_oh;
                            owner  <= win;
                            rr_ptr <= nxt_ptr;
                            hold   <= '0;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
